// File: rtl/control_pipe_regs.sv
// Control-side ID/EX, EX/MEM and MEM/WB registers, plus the one-cycle decode squash strobe
// and saturating instruction/bubble counters used for CPI measurement.
module control_pipe_regs #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic             JumpLinkD,
  input  logic [3:0]       ALUopD,
  input  logic             BranchD,
  input  logic             BneD,
  input  logic             JumpD,
  input  logic             EqualD,
  input  logic             StallD,
  input  logic             FlushE,
  output logic             ClearD,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             RegDstE,
  output logic             JumpLinkE,
  output logic [3:0]       ALUopE,
  output logic             ValidE,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             MemWriteM,
  output logic             JumpLinkM,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic             JumpLinkW,
  output logic [CNT_W-1:0] InstrCount,
  output logic [CNT_W-1:0] BubbleCount
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_r;
  state_t state_next_s;
  logic   taken_s;
  logic   redirect_s;
  logic   bub_s;

  // ClearD is a direct decode of the state flop, so it carries no combinational input path.
  assign ClearD = (state_r == SQUASH);

  // Branch resolution and EX bubble decision.
  always_comb begin
    taken_s = 1'b0;
    if (BranchD) begin
      taken_s = BneD ? ~EqualD : EqualD;
    end else begin
      taken_s = 1'b0;
    end
    redirect_s = JumpD | taken_s;
    bub_s      = StallD | FlushE | ClearD;
  end

  // Squash FSM next state; a redirect seen during SQUASH belongs to the wrong-path instruction.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (redirect_s && !StallD && !FlushE) begin
          state_next_s = SQUASH;
        end else begin
          state_next_s = IDLE;
        end
      end
      SQUASH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Squash FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // ID/EX register; jumps force ALUopE to zero so an undefined decode op never reaches EX.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      MemWriteE <= 1'b0;
      ALUSrcE   <= 1'b0;
      RegDstE   <= 1'b0;
      JumpLinkE <= 1'b0;
      ALUopE    <= 4'b0000;
      ValidE    <= 1'b0;
    end else if (bub_s) begin
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      MemWriteE <= 1'b0;
      ALUSrcE   <= 1'b0;
      RegDstE   <= 1'b0;
      JumpLinkE <= 1'b0;
      ALUopE    <= 4'b0000;
      ValidE    <= 1'b0;
    end else begin
      RegWriteE <= RegWriteD;
      MemtoRegE <= MemtoRegD;
      MemWriteE <= MemWriteD;
      ALUSrcE   <= ALUSrcD;
      RegDstE   <= RegDstD;
      JumpLinkE <= JumpLinkD;
      ALUopE    <= JumpD ? 4'b0000 : ALUopD;
      ValidE    <= 1'b1;
    end
  end

  // EX/MEM and MEM/WB registers always advance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
      JumpLinkM <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      JumpLinkW <= 1'b0;
    end else begin
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      MemWriteM <= MemWriteE;
      JumpLinkM <= JumpLinkE;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      JumpLinkW <= JumpLinkM;
    end
  end

  // Saturating CPI counters; exactly one of them advances per cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      InstrCount  <= '0;
      BubbleCount <= '0;
    end else if (bub_s) begin
      if (BubbleCount != CNT_MAX) begin
        BubbleCount <= BubbleCount + CNT_ONE;
      end else begin
        BubbleCount <= BubbleCount;
      end
    end else begin
      if (InstrCount != CNT_MAX) begin
        InstrCount <= InstrCount + CNT_ONE;
      end else begin
        InstrCount <= InstrCount;
      end
    end
  end

endmodule

// File: tb/tb_control_pipe_regs.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and random
// stimulus against a stage-list reference model (two DUTs: 32-bit and 4-bit counters).
module tb_control_pipe_regs;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RegWriteD = 1'b0, MemtoRegD = 1'b0, MemWriteD = 1'b0, ALUSrcD = 1'b0;
  logic RegDstD = 1'b0, JumpLinkD = 1'b0, BranchD = 1'b0, BneD = 1'b0;
  logic JumpD = 1'b0, EqualD = 1'b0, StallD = 1'b0, FlushE = 1'b0;
  logic [3:0] ALUopD = 4'b0000;

  logic ClearD, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, JumpLinkE, ValidE;
  logic [3:0] ALUopE;
  logic RegWriteM, MemtoRegM, MemWriteM, JumpLinkM, RegWriteW, MemtoRegW, JumpLinkW;
  logic [31:0] InstrCount, BubbleCount;

  logic b_ClearD, b_RegWriteE, b_MemtoRegE, b_MemWriteE, b_ALUSrcE, b_RegDstE, b_JumpLinkE, b_ValidE;
  logic [3:0] b_ALUopE;
  logic b_RegWriteM, b_MemtoRegM, b_MemWriteM, b_JumpLinkM, b_RegWriteW, b_MemtoRegW, b_JumpLinkW;
  logic [3:0] b_InstrCount, b_BubbleCount;

  control_pipe_regs dut (
    .CLK(CLK), .RST(RST), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .JumpLinkD(JumpLinkD), .ALUopD(ALUopD),
    .BranchD(BranchD), .BneD(BneD), .JumpD(JumpD), .EqualD(EqualD), .StallD(StallD),
    .FlushE(FlushE), .ClearD(ClearD), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .JumpLinkE(JumpLinkE),
    .ALUopE(ALUopE), .ValidE(ValidE), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .JumpLinkM(JumpLinkM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .JumpLinkW(JumpLinkW), .InstrCount(InstrCount), .BubbleCount(BubbleCount)
  );

  control_pipe_regs #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .JumpLinkD(JumpLinkD), .ALUopD(ALUopD),
    .BranchD(BranchD), .BneD(BneD), .JumpD(JumpD), .EqualD(EqualD), .StallD(StallD),
    .FlushE(FlushE), .ClearD(b_ClearD), .RegWriteE(b_RegWriteE), .MemtoRegE(b_MemtoRegE),
    .MemWriteE(b_MemWriteE), .ALUSrcE(b_ALUSrcE), .RegDstE(b_RegDstE), .JumpLinkE(b_JumpLinkE),
    .ALUopE(b_ALUopE), .ValidE(b_ValidE), .RegWriteM(b_RegWriteM), .MemtoRegM(b_MemtoRegM),
    .MemWriteM(b_MemWriteM), .JumpLinkM(b_JumpLinkM), .RegWriteW(b_RegWriteW),
    .MemtoRegW(b_MemtoRegW), .JumpLinkW(b_JumpLinkW), .InstrCount(b_InstrCount),
    .BubbleCount(b_BubbleCount)
  );

  always #5 CLK = ~CLK;

  logic [18:0] obs_a, obs_b;
  assign obs_a = {ClearD, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, JumpLinkE, ALUopE,
                  ValidE, RegWriteM, MemtoRegM, MemWriteM, JumpLinkM, RegWriteW, MemtoRegW, JumpLinkW};
  assign obs_b = {b_ClearD, b_RegWriteE, b_MemtoRegE, b_MemWriteE, b_ALUSrcE, b_RegDstE, b_JumpLinkE,
                  b_ALUopE, b_ValidE, b_RegWriteM, b_MemtoRegM, b_MemWriteM, b_JumpLinkM,
                  b_RegWriteW, b_MemtoRegW, b_JumpLinkW};

  int checks = 0;
  int errors = 0;

  // Reference model: list of stage contents (0=EX, 1=MEM, 2=WB) plus pending squash flag.
  typedef struct packed {
    logic rw, mtr, mw, als, rd, jl;
    logic [3:0] alu;
    logic v;
  } ctl_t;
  ctl_t   pipe [3];
  logic   m_clear;
  longint m_instr, m_bub;

  typedef struct {
    logic [7:0] ib;     // {rw, rd, br, bne, jmp, eq, stall, flush}
    logic [3:0] alu;
    logic [4:0] eb;     // {ClearD, RegWriteE, RegWriteM, RegWriteW, ValidE}
    logic [3:0] ealu;
    int         ei;
    int         ebb;
  } vec_t;
  vec_t vt [17];

  function automatic vec_t mk(logic [7:0] ib, logic [3:0] alu, logic [4:0] eb,
                              logic [3:0] ealu, int ei, int ebb);
    vec_t r;
    r.ib = ib; r.alu = alu; r.eb = eb; r.ealu = ealu; r.ei = ei; r.ebb = ebb;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [18:0] exp_vec();
    return {m_clear, pipe[0].rw, pipe[0].mtr, pipe[0].mw, pipe[0].als, pipe[0].rd, pipe[0].jl,
            pipe[0].alu, pipe[0].v, pipe[1].rw, pipe[1].mtr, pipe[1].mw, pipe[1].jl,
            pipe[2].rw, pipe[2].mtr, pipe[2].jl};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_clear = 1'b0;
    m_instr = 0;
    m_bub   = 0;
  endtask

  task automatic model_step();
    logic taken, redir, bub;
    ctl_t nxt;
    taken = BranchD & (BneD ? ~EqualD : EqualD);
    redir = JumpD | taken;
    bub   = StallD | FlushE | m_clear;
    nxt   = '0;
    if (!bub) nxt = {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, JumpLinkD,
                     (JumpD ? 4'b0000 : ALUopD), 1'b1};
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nxt;
    if (bub) m_bub++;
    else     m_instr++;
    m_clear = !m_clear && redir && !StallD && !FlushE;
  endtask

  task automatic check_all(string tag);
    chk({tag, "_ctl32"}, 64'(obs_a), 64'(exp_vec()));
    chk({tag, "_ctl4"},  64'(obs_b), 64'(exp_vec()));
    chk({tag, "_instr32"}, 64'(InstrCount),  64'(sat(m_instr, 32)));
    chk({tag, "_bub32"},   64'(BubbleCount), 64'(sat(m_bub, 32)));
    chk({tag, "_instr4"},  64'(b_InstrCount),  64'(sat(m_instr, 4)));
    chk({tag, "_bub4"},    64'(b_BubbleCount), 64'(sat(m_bub, 4)));
  endtask

  task automatic zero_inputs();
    {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, JumpLinkD} = 6'b000000;
    {BranchD, BneD, JumpD, EqualD, StallD, FlushE} = 6'b000000;
    ALUopD = 4'b0000;
  endtask

  // Clocked step: advance model with the inputs now applied, then sample #1 after the edge.
  task automatic cycle(string tag);
    model_step();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    zero_inputs();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    model_reset();
    check_all("reset");
    RST = 1'b0;
  endtask

  initial begin
    vt[0]  = mk(8'b1100_0000, 4'd2,  5'b01001, 4'd2, 1,  0);
    vt[1]  = mk(8'b0000_0000, 4'd0,  5'b00101, 4'd0, 2,  0);
    vt[2]  = mk(8'b0000_0000, 4'd0,  5'b00011, 4'd0, 3,  0);
    vt[3]  = mk(8'b0010_0100, 4'd0,  5'b10001, 4'd0, 4,  0);
    vt[4]  = mk(8'b1000_1000, 4'd3,  5'b00000, 4'd0, 4,  1);
    vt[5]  = mk(8'b0000_0000, 4'd0,  5'b00001, 4'd0, 5,  1);
    vt[6]  = mk(8'b0011_0100, 4'd0,  5'b00001, 4'd0, 6,  1);
    vt[7]  = mk(8'b0000_1000, 4'd15, 5'b10001, 4'd0, 7,  1);
    vt[8]  = mk(8'b1000_1000, 4'd0,  5'b00000, 4'd0, 7,  2);
    vt[9]  = mk(8'b0000_0000, 4'd0,  5'b00001, 4'd0, 8,  2);
    vt[10] = mk(8'b0010_0110, 4'd0,  5'b00000, 4'd0, 8,  3);
    vt[11] = mk(8'b0010_0110, 4'd0,  5'b00000, 4'd0, 8,  4);
    vt[12] = mk(8'b0010_0100, 4'd0,  5'b10001, 4'd0, 9,  4);
    vt[13] = mk(8'b0000_0000, 4'd0,  5'b00000, 4'd0, 9,  5);
    vt[14] = mk(8'b0000_0011, 4'd0,  5'b00000, 4'd0, 9,  6);
    vt[15] = mk(8'b0010_0101, 4'd0,  5'b00000, 4'd0, 9,  7);
    vt[16] = mk(8'b0000_0000, 4'd0,  5'b00001, 4'd0, 10, 7);

    model_reset();
    do_reset();

    // Directed table: pipeline walk, branch taken/not taken, jump squash, stall, flush.
    for (int i = 0; i < 17; i++) begin
      zero_inputs();
      {RegWriteD, RegDstD, BranchD, BneD, JumpD, EqualD, StallD, FlushE} = vt[i].ib;
      ALUopD = vt[i].alu;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_clear", i), 64'(ClearD), 64'(vt[i].eb[4]));
      chk($sformatf("vec%0d_pipe", i), 64'({RegWriteE, RegWriteM, RegWriteW, ValidE, ALUopE}),
          64'({vt[i].eb[3:0], vt[i].ealu}));
      chk($sformatf("vec%0d_instr", i), 64'(InstrCount), 64'(vt[i].ei));
      chk($sformatf("vec%0d_bub", i), 64'(BubbleCount), 64'(vt[i].ebb));
    end

    // Jump with undefined ALU op, then a second jump while squashing.
    do_reset();
    JumpD = 1'b1; ALUopD = 4'bxxxx;
    cycle("jmpx1");
    chk("jmpx_aluop", 64'(ALUopE), 64'(4'b0000));
    chk("jmpx_clear", 64'(ClearD), 64'(1'b1));
    cycle("jmpx2");
    chk("jmpx_no_second_pulse", 64'(ClearD), 64'(1'b0));
    zero_inputs();
    cycle("jmpx3");
    chk("jmpx_quiet", 64'(ClearD), 64'(1'b0));

    // Saturation: 20 unstalled cycles saturate the 4-bit instruction counter at 15.
    do_reset();
    for (int i = 0; i < 20; i++) cycle("satrun");
    chk("sat_instr4", 64'(b_InstrCount), 64'(4'd15));
    chk("sat_instr32", 64'(InstrCount), 64'(32'd20));

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, JumpLinkD} = 6'($urandom);
      ALUopD  = 4'($urandom);
      BranchD = ($urandom_range(0, 2) == 0);
      BneD    = 1'($urandom);
      EqualD  = 1'($urandom);
      JumpD   = ($urandom_range(0, 5) == 0);
      StallD  = ($urandom_range(0, 4) == 0);
      FlushE  = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    // Asynchronous reset mid-stream with RegWriteD held high.
    zero_inputs();
    RegWriteD = 1'b1;
    RST = 1'b1;
    #2;
    model_reset();
    check_all("async_rst");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    RegWriteD = 1'b1;
    cycle("post_rst");
    chk("post_rst_regwritee", 64'(RegWriteE), 64'(1'b1));
    chk("post_rst_valide", 64'(ValidE), 64'(1'b1));
    chk("post_rst_instr", 64'(InstrCount), 64'(32'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
